bomb_controller: RTL

Sequences the lifecycle of the player's single bomb: placement, fuse countdown, blast and return to idle. Sits beside the player-movement block in the top level. It takes the player sprite origin and a place button, snaps the bomb to the 16-pixel tile grid, and drives the pixel-coverage flags and blast outputs that the top-level mux and collision logic consume.

---
 rtl/bomb_if.sv | 30 +++
 rtl/bomb_controller.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/bomb_if.sv
// Signal bundle between the bomb controller and the top-level player, mux and collision logic.
// The master drives the player and pixel inputs. The slave (bomb_controller) drives the bomb and blast outputs.
interface bomb_if;
    logic       place;
    logic       game_over;
    logic [9:0] b_x;
    logic [9:0] b_y;
    logic [9:0] v_x;
    logic [9:0] v_y;
    logic [9:0] bomb_x;
    logic [9:0] bomb_y;
    logic       bomb_active;
    logic       blast_active;
    logic       blast_start;
    logic       bomb_on;
    logic       blast_on;
    logic       player_hit;

    modport master (
        output place, game_over, b_x, b_y, v_x, v_y,
        input  bomb_x, bomb_y, bomb_active, blast_active, blast_start,
               bomb_on, blast_on, player_hit
    );

    modport slave (
        input  place, game_over, b_x, b_y, v_x, v_y,
        output bomb_x, bomb_y, bomb_active, blast_active, blast_start,
               bomb_on, blast_on, player_hit
    );
endinterface

// File: rtl/bomb_controller.sv
// Single-bomb lifecycle: placement snapped to the tile grid, fuse countdown, blast cross and return to idle.
// The controller also produces the pixel-coverage flags and the registered player-hit flag.
module bomb_controller #(
    parameter int FUSE_CYCLES  = 200000000,
    parameter int BLAST_CYCLES = 50000000,
    parameter int BLAST_LEN    = 2,
    parameter int TILE         = 16,
    parameter int MIN_X        = 143,
    parameter int MAX_X        = 784,
    parameter int MIN_Y        = 34,
    parameter int MAX_Y        = 516
) (
    input  logic  clk,
    input  logic  reset,
    bomb_if.slave bus
);
    localparam int MAX_CYC = (FUSE_CYCLES > BLAST_CYCLES) ? FUSE_CYCLES : BLAST_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int TILE_SH = $clog2(TILE);
    localparam logic [CNT_W-1:0] FUSE_LAST  = CNT_W'(FUSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLAST_LAST = CNT_W'(BLAST_CYCLES - 1);
    localparam logic [10:0] KX_MAX = 11'((MAX_X - MIN_X - TILE) / TILE);
    localparam logic [10:0] KY_MAX = 11'((MAX_Y - MIN_Y - TILE) / TILE);
    localparam logic signed [10:0] SPAN_S = 11'(BLAST_LEN * TILE);
    localparam logic signed [10:0] T1_S   = 11'(TILE - 1);
    localparam logic signed [10:0] MINX_S = 11'(MIN_X);
    localparam logic signed [10:0] MINY_S = 11'(MIN_Y);
    localparam logic signed [10:0] XLIM_S = 11'(MAX_X - 1);
    localparam logic signed [10:0] YLIM_S = 11'(MAX_Y - 1);

    typedef enum logic [1:0] {IDLE, ARMED, EXPLODE} state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              place_q, place_rise, latch, start_n;
    logic [9:0]        bomb_x_q, bomb_y_q;
    logic              blast_start_q, player_hit_q;
    logic signed [10:0] bx, by, bx_hi, by_hi, hx_lo, hx_hi, vy_lo, vy_hi;
    logic signed [10:0] vx, vy, px, py, px_hi, py_hi;
    logic              pix_h, pix_v, box_h, box_v;

    // Round to the nearest tile, pin anything left/above the play area to tile 0, clamp at the last full tile.
    function automatic logic [9:0] snap(input logic [9:0] p, input logic [10:0] lo, input logic [10:0] kmax);
        logic [10:0] off, k;
        off = {1'b0, p} - lo + 11'(TILE / 2);
        k   = ({1'b0, p} < lo) ? 11'd0 : (off >> TILE_SH);
        if (k > kmax) k = kmax;
        return 10'(lo + (k << TILE_SH));
    endfunction

    function automatic logic signed [10:0] smax(input logic signed [10:0] a, input logic signed [10:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic signed [10:0] smin(input logic signed [10:0] a, input logic signed [10:0] b);
        return (a < b) ? a : b;
    endfunction

    assign place_rise = bus.place & ~place_q;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        start_n = 1'b0;
        latch   = 1'b0;
        case (state)
            IDLE: begin
                if (place_rise && !bus.game_over) begin
                    state_n = ARMED;
                    cnt_n   = '0;
                    latch   = 1'b1;
                end
            end
            ARMED: begin
                if (bus.game_over) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == FUSE_LAST) begin
                    state_n = EXPLODE;
                    cnt_n   = '0;
                    start_n = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            EXPLODE: begin
                if (bus.game_over || cnt == BLAST_LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Cross geometry in signed 11 bits so arms reaching past the top/left edge clip instead of wrapping.
    assign bx    = signed'({1'b0, bomb_x_q});
    assign by    = signed'({1'b0, bomb_y_q});
    assign bx_hi = bx + T1_S;
    assign by_hi = by + T1_S;
    assign hx_lo = smax(bx - SPAN_S, MINX_S);
    assign hx_hi = smin(bx_hi + SPAN_S, XLIM_S);
    assign vy_lo = smax(by - SPAN_S, MINY_S);
    assign vy_hi = smin(by_hi + SPAN_S, YLIM_S);

    assign vx    = signed'({1'b0, bus.v_x});
    assign vy    = signed'({1'b0, bus.v_y});
    assign pix_h = (vx >= hx_lo) && (vx <= hx_hi) && (vy >= by) && (vy <= by_hi);
    assign pix_v = (vx >= bx) && (vx <= bx_hi) && (vy >= vy_lo) && (vy <= vy_hi);

    assign px    = signed'({1'b0, bus.b_x});
    assign py    = signed'({1'b0, bus.b_y});
    assign px_hi = px + T1_S;
    assign py_hi = py + T1_S;
    assign box_h = (px <= hx_hi) && (px_hi >= hx_lo) && (py <= by_hi) && (py_hi >= by);
    assign box_v = (px <= bx_hi) && (px_hi >= bx) && (py <= vy_hi) && (py_hi >= vy_lo);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            place_q       <= 1'b0;
            bomb_x_q      <= 10'(MIN_X);
            bomb_y_q      <= 10'(MIN_Y);
            blast_start_q <= 1'b0;
            player_hit_q  <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            place_q       <= bus.place;
            blast_start_q <= start_n;
            player_hit_q  <= (state == EXPLODE) && (box_h || box_v);
            if (latch) begin
                bomb_x_q <= snap(bus.b_x, 11'(MIN_X), KX_MAX);
                bomb_y_q <= snap(bus.b_y, 11'(MIN_Y), KY_MAX);
            end
        end
    end

    assign bus.bomb_x       = bomb_x_q;
    assign bus.bomb_y       = bomb_y_q;
    assign bus.bomb_active  = (state == ARMED);
    assign bus.blast_active = (state == EXPLODE);
    assign bus.blast_start  = blast_start_q;
    assign bus.player_hit   = player_hit_q;
    assign bus.bomb_on      = (state == ARMED) && (vx >= bx) && (vx <= bx_hi) && (vy >= by) && (vy <= by_hi);
    assign bus.blast_on     = (state == EXPLODE) && (pix_h || pix_v);
endmodule
